// File: rtl/psel_generator.sv
// -----------------------------------------------------------------------------
// psel_generator
//
// Registered multi-grant priority selector. Each cycle up to REQS distinct
// requesters are picked from the WIDTH-bit request vector. Grant slots
// alternate between the low-index and high-index ends of the vector:
// slot 0 takes the lowest request, slot 1 the highest, slot 2 the next
// lowest, and so on. This way both ends of the vector are served.
//
// Ports:
//   clock    in   1           rising-edge clock
//   reset    in   1           synchronous active-high reset (clears output)
//   en       in   1           selection enable; when low the output clears
//   req      in   WIDTH       request vector, bit i = requester i
//   gnt_bus  out  WIDTH*REQS  one-hot grant per slot; slot k at
//                             [k*WIDTH +: WIDTH], slot 0 at the LSBs
//
// The output is driven straight from a register. There is no combinational
// path from the inputs to gnt_bus.
// -----------------------------------------------------------------------------
module psel_generator #(
   parameter int REQS  = 3,
   parameter int WIDTH = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    en,
   input  logic [WIDTH-1:0]        req,
   output logic [WIDTH*REQS-1:0]   gnt_bus
);

   // Lowest set bit: two's-complement trick isolates the least significant one.
   function automatic logic [WIDTH-1:0] f_lowest(input logic [WIDTH-1:0] v);
      return v & (~v + WIDTH'(1));
   endfunction

   // Highest set bit: an ascending scan, where the last hit wins.
   function automatic logic [WIDTH-1:0] f_highest(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) begin
            r    = '0;
            r[i] = 1'b1;
         end
      end
      return r;
   endfunction

   // w_avail[k] holds the requests that are still ungranted when slot k
   // is considered. Each stage of the chain removes the bit its slot took.
   logic [REQS-1:0][WIDTH-1:0] w_avail;
   logic [REQS-1:0][WIDTH-1:0] w_slot;
   logic [WIDTH*REQS-1:0]      r_gnt;

   genvar gi;
   generate
      for (gi = 0; gi < REQS; gi++) begin : g_slot
         if (gi == 0) begin : g_first
            assign w_avail[gi] = req;
         end else begin : g_chain
            assign w_avail[gi] = w_avail[gi-1] & ~w_slot[gi-1];
         end

         // Even slots scan from the low end, odd slots from the high end.
         if ((gi % 2) == 0) begin : g_low
            assign w_slot[gi] = f_lowest(w_avail[gi]);
         end else begin : g_high
            assign w_slot[gi] = f_highest(w_avail[gi]);
         end
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset) begin
         r_gnt <= '0;
      end else if (en) begin
         r_gnt <= w_slot;
      end else begin
         r_gnt <= '0;
      end
   end

   assign gnt_bus = r_gnt;

endmodule

// File: tb/tb_psel_generator.sv
// -----------------------------------------------------------------------------
// tb_psel_generator
//
// Directed testbench for psel_generator with REQS=3 and WIDTH=16. Each
// scenario task drives its stimulus and compares the registered grant bus
// one time unit after the rising edge. The incrementing sweep checks every
// cycle against a reference selector. That selector lists the request bits
// in ascending order and hands them out alternately from both ends.
// -----------------------------------------------------------------------------
module tb_psel_generator;

   localparam int REQS  = 3;
   localparam int WIDTH = 16;

   logic                   clock;
   logic                   reset;
   logic                   en;
   logic [WIDTH-1:0]       req;
   logic [WIDTH*REQS-1:0]  gnt_bus;

   int n_checks;
   int n_pass;

   psel_generator #(.REQS(REQS), .WIDTH(WIDTH)) dut (
      .clock   (clock),
      .reset   (reset),
      .en      (en),
      .req     (req),
      .gnt_bus (gnt_bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Wait for the rising edge, then move just past it before sampling.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Reference selection: sort the set bits ascending. Slot 2j gets b_j and
   // slot 2j+1 gets b_(n-1-j), while slots remain and bits are left.
   function automatic logic [WIDTH*REQS-1:0] ref_sel(input logic [WIDTH-1:0] r);
      int idx [WIDTH];
      int n;
      int pos;
      logic [WIDTH*REQS-1:0] g;
      n = 0;
      g = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (r[i]) begin
            idx[n] = i;
            n++;
         end
      end
      for (int k = 0; k < REQS; k++) begin
         if (k < n) begin
            pos = ((k % 2) == 0) ? idx[k/2] : idx[n-1-(k/2)];
            g[k*WIDTH + pos] = 1'b1;
         end
      end
      return g;
   endfunction

   task automatic test_reset();
      reset = 1'b1; en = 1'b1; req = 16'hFFFF;
      step();
      n_checks++;
      if (gnt_bus !== 48'h0) $display("FAIL reset_edge1 got=%h want=%h", gnt_bus, 48'h0);
      else n_pass++;
      step();
      n_checks++;
      if (gnt_bus !== 48'h0) $display("FAIL reset_edge2 got=%h want=%h", gnt_bus, 48'h0);
      else n_pass++;
      reset = 1'b0;
      step();
      n_checks++;
      if (gnt_bus !== 48'h0002_8000_0001)
         $display("FAIL reset_release got=%h want=%h", gnt_bus, 48'h0002_8000_0001);
      else n_pass++;
      $display("reset: release -> gnt_bus=%h", gnt_bus);
   endtask

   task automatic test_full();
      en = 1'b1; req = 16'hFFFF;
      step();
      n_checks++;
      if (gnt_bus !== 48'h0002_8000_0001)
         $display("FAIL full_req got=%h want=%h", gnt_bus, 48'h0002_8000_0001);
      else n_pass++;
      $display("full: req=%h gnt_bus=%h", req, gnt_bus);
   endtask

   task automatic test_sparse();
      logic [WIDTH-1:0]      vec_req [4];
      logic [WIDTH*REQS-1:0] vec_exp [4];
      vec_req[0] = 16'h0000; vec_exp[0] = 48'h0000_0000_0000;
      vec_req[1] = 16'h0001; vec_exp[1] = 48'h0000_0000_0001;
      vec_req[2] = 16'h8001; vec_exp[2] = 48'h0000_8000_0001;
      vec_req[3] = 16'h0110; vec_exp[3] = 48'h0000_0100_0010;
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req = vec_req[i];
         step();
         n_checks++;
         if (gnt_bus !== vec_exp[i])
            $display("FAIL sparse[%0d] req=%h got=%h want=%h", i, req, gnt_bus, vec_exp[i]);
         else n_pass++;
         $display("sparse: req=%h gnt_bus=%h", req, gnt_bus);
      end
   endtask

   task automatic test_enable();
      req = 16'hFFFF; en = 1'b0;
      step();
      n_checks++;
      if (gnt_bus !== 48'h0) $display("FAIL en_low got=%h want=%h", gnt_bus, 48'h0);
      else n_pass++;
      $display("enable: en=0 gnt_bus=%h", gnt_bus);
      en = 1'b1;
      step();
      n_checks++;
      if (gnt_bus !== 48'h0002_8000_0001)
         $display("FAIL en_restore got=%h want=%h", gnt_bus, 48'h0002_8000_0001);
      else n_pass++;
      $display("enable: en=1 gnt_bus=%h", gnt_bus);
   endtask

   task automatic test_oversub();
      en = 1'b1; req = 16'h00F0;
      step();
      n_checks++;
      if (gnt_bus !== 48'h0020_0080_0010)
         $display("FAIL oversub got=%h want=%h", gnt_bus, 48'h0020_0080_0010);
      else n_pass++;
      $display("oversub: req=%h gnt_bus=%h", req, gnt_bus);
   endtask

   task automatic test_back_to_back_sweep();
      logic [WIDTH-1:0]      cur;
      logic [WIDTH*REQS-1:0] want;
      logic [WIDTH-1:0]      s [REQS];
      logic [WIDTH-1:0]      uni;
      int                    nz;
      int                    pc;
      logic                  bad;
      cur = 16'hFFFF;
      for (int c = 0; c < 220; c++) begin
         req   = cur;
         reset = (c == 50 || c == 51 || c == 150);
         en    = !(c >= 100 && c <= 102) && (c != 170);
         want  = (reset || !en) ? '0 : ref_sel(cur);
         step();
         n_checks++;
         if (gnt_bus !== want)
            $display("FAIL sweep[%0d] req=%h rst=%0b en=%0b got=%h want=%h",
                     c, req, reset, en, gnt_bus, want);
         else n_pass++;

         // Structural properties: one-hot slots, disjoint slots, a subset of
         // req, and a count of non-zero slots equal to min(popcount, REQS).
         bad = 1'b0;
         uni = '0;
         nz  = 0;
         for (int k = 0; k < REQS; k++) begin
            s[k] = gnt_bus[k*WIDTH +: WIDTH];
            if ((s[k] & (s[k] - 16'd1)) != '0) bad = 1'b1;
            if ((uni & s[k]) != '0) bad = 1'b1;
            uni = uni | s[k];
            if (s[k] != '0) nz++;
         end
         if ((uni & ~cur) != '0) bad = 1'b1;
         pc = $countones(cur);
         if (!reset && en && nz != ((pc < REQS) ? pc : REQS)) bad = 1'b1;
         n_checks++;
         if (bad)
            $display("FAIL sweep_props[%0d] req=%h got=%h nonzero=%0d popcount=%0d",
                     c, req, gnt_bus, nz, pc);
         else n_pass++;
         $display("sweep[%0d]: req=%h rst=%0b en=%0b gnt_bus=%h", c, req, reset, en, gnt_bus);
         cur = cur + 16'd1;
      end
      reset = 1'b0;
      en    = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset = 1'b1;
      en    = 1'b0;
      req   = '0;
      test_reset();
      test_full();
      test_sparse();
      test_enable();
      test_oversub();
      test_back_to_back_sweep();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
